sub_bytes_serial: RTL and testbench
===================================

SUB_BYTES_SERIAL -- requirements
Module: sub_bytes_serial

Interface
REQ-001 SHALL have parameter LANES, default 1, giving the number of S-box lookups per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port clear, input, 1, synchronous abort.
REQ-005 SHALL have port data_in, input, 128, AES state to substitute; byte i = data_in[8i+7:8i].
REQ-006 SHALL have port data_in_valid, input, 1, upstream offers data_in.
REQ-007 SHALL have port data_in_ready, output, 1, block can accept data_in.
REQ-008 SHALL have port data_out, output, 128, substituted state, same byte mapping as data_in.
REQ-009 SHALL have port data_out_valid, output, 1, data_out holds a complete result.
REQ-010 SHALL have port data_out_ready, input, 1, downstream accepts data_out.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL implement three states: IDLE, SUBST and DONE.
REQ-013 Input handshake SHALL occur on any rising edge where data_in_valid and data_in_ready are both high; data_in SHALL be loaded into a 128-bit working register, the byte counter SHALL be cleared to 0, and the state SHALL go to SUBST.
REQ-014 data_in_ready SHALL be high in IDLE, equal to data_out_ready in DONE, and low in SUBST.
REQ-015 Each SUBST cycle SHALL replace bytes counter..counter+LANES-1 of the working register with their S-box images and advance the counter by LANES, using 4-bit arithmetic.
REQ-016 When the bytes substituted in the current cycle include byte 15, the state SHALL go to DONE and the counter SHALL wrap to 0.
REQ-017 Latency SHALL be exactly 16/LANES cycles from the input-handshake edge to the first cycle with data_out_valid high (16 cycles for LANES=1).
REQ-018 data_out SHALL always equal the working register; it is meaningful only while data_out_valid is high.
REQ-019 data_out_valid SHALL be high only in DONE, and data_out SHALL stay stable until output handshake.
REQ-020 On an output handshake with no simultaneous input handshake, the block SHALL go from DONE to IDLE.
REQ-021 On output and input handshakes in the same cycle, the block SHALL load the new data_in and go directly to SUBST with no idle bubble.
REQ-022 data_in_valid asserted during SUBST SHALL be ignored; no load and no corruption of the working register.
REQ-023 clear high SHALL force IDLE, counter 0 and data_out_valid low on the next edge from any state, overriding any handshake in that cycle; the working register SHALL be unchanged.
REQ-024 A configuration with LANES not dividing 16 SHALL be rejected by an elaboration-time check.

Reset
REQ-025 n_rst low SHALL immediately force: state IDLE, counter 0, working register 0, data_out 128'h0, data_out_valid 0, busy 0, data_in_ready 1.
REQ-026 Reset asserted mid-SUBST or mid-DONE SHALL discard the block in flight; after release the block SHALL be in IDLE and ready.

Structure
REQ-027 The state enum (IDLE, SUBST, DONE) and constant AES_STATE_BYTES = 16 SHALL be defined in the shared AES package.
REQ-028 SHALL instantiate LANES copies of the team's existing combinational Rijndael S-box lookup (8-bit s_box_in, 8-bit s_box_out) as its only sub-module.
REQ-029 The S-box inputs SHALL be selected from the working register by counter.
REQ-030 SHALL contain no other lookup tables.

Verification
REQ-031 LANES=1, data_in all 0x00, data_out_ready high -> data_out all 0x63 exactly 16 cycles after accept; data_out_valid high for 1 cycle.
REQ-032 data_in bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 -> data_out bytes d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30; repeat with LANES=4 -> same result after 4 cycles.
REQ-033 data_out_ready held low 10 cycles in DONE -> data_out_valid and data_out stable; data_in_ready low; no second block accepted.
REQ-034 Back-to-back blocks with both valids and readys high -> new block loaded on the output-handshake edge; second result appears 16 cycles later; no bubble.
REQ-035 clear pulsed at SUBST cycle 7 -> IDLE next edge, data_out_valid never asserted; next block processes correctly.
REQ-036 n_rst asserted asynchronously mid-SUBST -> outputs at reset values before the next edge; a post-release block with all bytes 0x53 -> all bytes 0xed.

Source files
------------

// File: rtl/sub_bytes_serial_pkg.sv
// Shared AES definitions for the serial SubBytes block: state geometry and
// the controller state encoding.
package sub_bytes_serial_pkg;

  localparam int AES_STATE_BYTES = 16;
  localparam int AES_STATE_BITS  = AES_STATE_BYTES * 8;
  localparam int BYTE_IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUBST = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sub_bytes_serial_sbox.sv
// Combinational Rijndael S-box: one byte in, its substituted image out.
module sub_bytes_serial_sbox (
  input  logic [7:0] s_box_in,
  output logic [7:0] s_box_out
);

  // Entry 0 sits in the top byte, so entry i lives at bits {~i, 3'b111} -: 8.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_box_out = SBOX_TABLE[{~s_box_in, 3'b111} -: 8];

endmodule

// File: rtl/sub_bytes_serial.sv
// Serial AES SubBytes: substitutes a 128-bit state LANES bytes per cycle
// behind valid/ready handshakes on both sides.
module sub_bytes_serial
  import sub_bytes_serial_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      clear,
  input  logic [AES_STATE_BITS-1:0] data_in,
  input  logic                      data_in_valid,
  output logic                      data_in_ready,
  output logic [AES_STATE_BITS-1:0] data_out,
  output logic                      data_out_valid,
  input  logic                      data_out_ready,
  output logic                      busy
);

  if ((LANES < 1) || (LANES > AES_STATE_BYTES) || ((AES_STATE_BYTES % LANES) != 0)) begin : g_bad_lanes
    $error("sub_bytes_serial: LANES=%0d must divide %0d", LANES, AES_STATE_BYTES);
  end

  state_e                    state_q, state_d;
  logic [BYTE_IDX_W-1:0]     cnt_q, cnt_d;
  logic [AES_STATE_BITS-1:0] work_q, work_d;

  logic [BYTE_IDX_W-1:0] lane_idx [LANES];
  logic [7:0]            sbox_in  [LANES];
  logic [7:0]            sbox_out [LANES];
  logic                  last_lane;
  logic                  in_hs;
  logic                  out_hs;

  // Lane l works on byte cnt_q + l; cnt_q is always a multiple of LANES.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = cnt_q + BYTE_IDX_W'(l);
      sbox_in[l]  = work_q[{lane_idx[l], 3'b000} +: 8];
    end
    last_lane = (cnt_q + BYTE_IDX_W'(LANES - 1)) == {BYTE_IDX_W{1'b1}};
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sub_bytes_serial_sbox u_sbox (
      .s_box_in  (sbox_in[g]),
      .s_box_out (sbox_out[g])
    );
  end

  // NOTE: the working register is reset as well, so data_out reads as zero
  // straight out of reset instead of leaking stale state.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // NOTE: every _d defaults to its _q first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_hs) begin
            work_d  = data_in;
            cnt_d   = '0;
            state_d = SUBST;
          end
        end
        SUBST: begin
          for (int l = 0; l < LANES; l++) begin
            work_d[{lane_idx[l], 3'b000} +: 8] = sbox_out[l];
          end
          cnt_d = cnt_q + BYTE_IDX_W'(LANES);
          if (last_lane) begin
            state_d = DONE;
            cnt_d   = '0;
          end
        end
        DONE: begin
          // A new block arriving with the output handshake skips IDLE.
          if (in_hs) begin
            work_d  = data_in;
            cnt_d   = '0;
            state_d = SUBST;
          end else if (out_hs) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_out       = work_q;
    data_out_valid = (state_q == DONE);
    busy           = (state_q != IDLE);
    unique case (state_q)
      IDLE:    data_in_ready = 1'b1;
      DONE:    data_in_ready = data_out_ready;
      default: data_in_ready = 1'b0;
    endcase
    in_hs  = data_in_valid & data_in_ready;
    out_hs = data_out_valid & data_out_ready;
  end

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Scoreboard bench for sub_bytes_serial: a LANES=1 and a LANES=4 instance,
// expected results from a GF(2^8) inverse + affine reference model.
module tb_sub_bytes_serial;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         clear          [2];
  logic [127:0] din            [2];
  logic         din_valid      [2];
  logic         din_ready      [2];
  logic [127:0] dout           [2];
  logic         dout_valid     [2];
  logic         dout_ready     [2];
  logic         busy           [2];

  exp_t         exp_q [2][$];
  logic [7:0]   sbox_ref [256];
  int           cyc    = 0;
  int           checks = 0;
  int           errors = 0;
  bit           rand_on;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: multiplicative inverse in GF(2^8) followed by the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_ref[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int L = (g == 0) ? 1 : 4;
    logic         seen = 1'b0;
    logic [127:0] hold;

    sub_bytes_serial #(.LANES(L)) u_dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .clear          (clear[g]),
      .data_in        (din[g]),
      .data_in_valid  (din_valid[g]),
      .data_in_ready  (din_ready[g]),
      .data_out       (dout[g]),
      .data_out_valid (dout_valid[g]),
      .data_out_ready (dout_ready[g]),
      .busy           (busy[g])
    );

    // Monitor: latency on first valid, stability while stalled, data on handshake.
    always @(negedge clk) begin
      #2;
      if (!n_rst) begin
        seen = 1'b0;
      end else if (dout_valid[g]) begin
        if (!seen) begin
          seen = 1'b1;
          hold = dout[g];
          if (exp_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid cfg%0d: valid high with no block pending", g);
          end else begin
            check($sformatf("latency cfg%0d", g), 128'(cyc - exp_q[g][0].acc), 128'(16 / L));
          end
        end else begin
          check($sformatf("dout_stable cfg%0d", g), dout[g], hold);
        end
        if (dout_ready[g] && exp_q[g].size() != 0) begin
          check($sformatf("dout_data cfg%0d", g), dout[g], exp_q[g][0].data);
          void'(exp_q[g].pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic offer(input int g, input logic [127:0] d, input logic [127:0] e);
    int budget = 0;
    din[g]       = d;
    din_valid[g] = 1'b1;
    #1;
    while (!din_ready[g] || clear[g]) begin
      if (budget++ > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout cfg%0d: ready never seen", g);
        din_valid[g] = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    exp_q[g].push_back('{data: e, acc: cyc + 1});
    @(negedge clk);
    din_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int budget = 0;
    while (exp_q[g].size() != 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q[g].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout cfg%0d: %0d blocks outstanding", g, exp_q[g].size());
      exp_q[g].delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input int g, input string tag);
    check($sformatf("%s dout cfg%0d", tag, g),      dout[g],              128'h0);
    check($sformatf("%s valid cfg%0d", tag, g),     128'(dout_valid[g]),  128'h0);
    check($sformatf("%s busy cfg%0d", tag, g),      128'(busy[g]),        128'h0);
    check($sformatf("%s in_ready cfg%0d", tag, g),  128'(din_ready[g]),   128'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] fips_in, fips_out, tmp;
    int           budget;
    fips_in  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
    fips_out = 128'h3052411ee55db4b8f198bfe0ae1127d4;

    n_rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      clear[g] = 1'b0; din[g] = '0; din_valid[g] = 1'b0; dout_ready[g] = 1'b1;
    end
    build_model();
    #2;
    check_reset_outputs(0, "reset");
    check_reset_outputs(1, "reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // All-zero state and the known-answer vector on both lane widths.
    offer(0, 128'h0, {16{8'h63}});
    wait_idle(0);
    offer(0, fips_in, fips_out);
    offer(1, fips_in, fips_out);
    wait_idle(0);
    wait_idle(1);

    // Back-to-back blocks: the second is accepted on the output-handshake edge.
    tmp = rnd128();
    offer(0, tmp, ref_sub(tmp));
    tmp = rnd128();
    offer(0, tmp, ref_sub(tmp));
    tmp = rnd128();
    offer(0, tmp, ref_sub(tmp));
    wait_idle(0);

    // Random traffic with random downstream back-pressure.
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(negedge clk);
          dout_ready[0] = ($urandom_range(0, 3) != 0);
          dout_ready[1] = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [127:0] d0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          d0 = rnd128();
          offer(0, d0, ref_sub(d0));
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          logic [127:0] d1;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          d1 = rnd128();
          offer(1, d1, ref_sub(d1));
        end
      end
    join
    rand_on = 1'b0;
    repeat (2) @(negedge clk);
    dout_ready[0] = 1'b1;
    dout_ready[1] = 1'b1;
    wait_idle(0);
    wait_idle(1);

    // Downstream stall in DONE with a competing block offered upstream.
    dout_ready[0] = 1'b0;
    tmp = rnd128();
    offer(0, tmp, ref_sub(tmp));
    budget = 0;
    while (!dout_valid[0] && budget < 40) begin
      @(negedge clk);
      #1;
      budget++;
    end
    din[0]       = rnd128();
    din_valid[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1;
      check("stall in_ready", 128'(din_ready[0]), 128'h0);
      check("stall valid",    128'(dout_valid[0]), 128'h1);
    end
    din_valid[0]  = 1'b0;
    dout_ready[0] = 1'b1;
    wait_idle(0);

    // Abort mid-substitution; the aborted block must never appear.
    tmp = rnd128();
    offer(0, tmp, ref_sub(tmp));
    repeat (6) @(negedge clk);
    clear[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0;
    #1;
    check("clear busy",     128'(busy[0]),       128'h0);
    check("clear valid",    128'(dout_valid[0]), 128'h0);
    check("clear in_ready", 128'(din_ready[0]),  128'h1);
    void'(exp_q[0].pop_back());
    repeat (20) @(negedge clk);
    tmp = rnd128();
    offer(0, tmp, ref_sub(tmp));
    wait_idle(0);

    // Asynchronous reset in the middle of SUBST.
    tmp = rnd128();
    offer(0, tmp, ref_sub(tmp));
    repeat (5) @(negedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check_reset_outputs(0, "async_rst");
    check_reset_outputs(1, "async_rst");
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    offer(0, {16{8'h53}}, {16{8'hed}});
    wait_idle(0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
